data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 105 ++++++++++
 tb/tb_data_mem_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed response latency. It serves one cache
// request at a time and supports byte-lane writes.
module data_mem_responder #(
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int LATENCY        = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_be,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_is_write,
   output logic                  busy
);

   localparam int LANE_W = DATA_WIDTH / 4;
   localparam int DEPTH  = 1 << MEM_ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                    state, state_nxt;
   logic [3:0]                cnt;
   logic [3:0]                be_q;
   logic [MEM_ADDR_WIDTH-1:0] idx_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH-1:0]     merged;
   logic [DATA_WIDTH-1:0]     mem [DEPTH];
   logic                      accept;
   logic                      commit;
   logic                      unused_addr_bits;

   // Byte offset and high address bits are dropped, so addresses alias modulo memory size.
   assign unused_addr_bits = ^{req_addr[1:0], req_addr[DATA_WIDTH-1:MEM_ADDR_WIDTH+2]};

   assign accept = req_valid && req_ready;
   assign commit = (state == WAIT) && (cnt == 4'd0);

   // State register, latency counter and response registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         rsp_rdata    <= '0;
         rsp_is_write <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state <= state_nxt;
         if (accept)
            cnt <= 4'(LATENCY - 1);
         else if (state == WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
         if (commit) begin
            rsp_rdata    <= merged;
            rsp_is_write <= (be_q != 4'b0000);
         end
      end
   end

   // Request capture; the fields only matter once the handshake has loaded them.
   always_ff @(posedge CLK) begin
      if (accept) begin
         be_q    <= req_be;
         idx_q   <= req_addr[MEM_ADDR_WIDTH+1:2];
         wdata_q <= req_wdata;
      end
   end

   // NOTE: the memory array has no reset; its contents survive RST_N by design.
   always_ff @(posedge CLK) begin
      if (RST_N && commit && be_q != 4'b0000)
         mem[idx_q] <= merged;
   end

   // Merged word: enabled lanes take new data, others keep the stored bytes.
   always_comb begin
      // NOTE: default first so no path through the loop leaves merged unassigned (no latch).
      merged = mem[idx_q];
      for (int i = 0; i < 4; i++)
         if (be_q[i])
            merged[i*LANE_W +: LANE_W] = wdata_q[i*LANE_W +: LANE_W];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = WAIT;
         WAIT:    if (cnt == 4'd0) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
      busy      = (state != IDLE);
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one LATENCY=4 instance for function and
// backpressure, one LATENCY=1 instance for back-to-back timing.
module tb_data_mem_responder;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_is_write, busy;
   logic [3:0]  req_be;
   logic [31:0] req_addr, req_wdata, rsp_rdata;

   logic        req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1, rsp_is_write_1, busy_1;
   logic [3:0]  req_be_1;
   logic [31:0] req_addr_1, req_wdata_1, rsp_rdata_1;

   typedef struct {
      logic [31:0] data;
      logic        is_wr;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] model_mem [int];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_responder #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(10), .LATENCY(LAT)) dut (
      .CLK(clk), .RST_N(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_be(req_be),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_is_write(rsp_is_write), .busy(busy)
   );

   data_mem_responder #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(10), .LATENCY(1)) dut1 (
      .CLK(clk), .RST_N(rst_n),
      .req_valid(req_valid_1), .req_ready(req_ready_1), .req_be(req_be_1),
      .req_addr(req_addr_1), .req_wdata(req_wdata_1),
      .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_rdata(rsp_rdata_1),
      .rsp_is_write(rsp_is_write_1), .busy(busy_1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
      return r;
   endfunction

   // Entered and left at posedge+#1. Garbage is driven on req_* while the request is in flight.
   task automatic do_req(input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold);
      int          n;
      int          lat;
      int          idx;
      logic [31:0] old;
      logic [31:0] held;
      exp_t        e;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      check("req_ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_be = be; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      idx = int'(addr[11:2]);
      old = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      e.data  = (be == 4'b0000) ? old : merge(old, wdata, be);
      e.is_wr = (be != 4'b0000);
      if (e.is_wr) model_mem[idx] = e.data;
      sb.push_back(e);
      req_be = 4'hF; req_addr = ~addr; req_wdata = $urandom;
      lat = 0;
      while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      check("latency", lat, LAT);
      held = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("bp_valid", {31'b0, rsp_valid}, 32'd1);
         check("bp_rdata_stable", rsp_rdata, held);
         check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("rsp_rdata", rsp_rdata, e.data);
         check("rsp_is_write", {31'b0, rsp_is_write}, {31'b0, e.is_wr});
      end else begin
         check("sb_empty", 32'd0, 32'd1);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      check("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("post_req_ready", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      int n;
      int acc;
      int prev;
      rst_n = 1'b0;
      req_valid = 1'b0; req_be = 4'h0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      req_valid_1 = 1'b0; req_be_1 = 4'h0; req_addr_1 = '0; req_wdata_1 = '0; rsp_ready_1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_is_write", {31'b0, rsp_is_write}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);

      do_req(4'hF, 32'h0000_0010, 32'hDEADBEEF, 0);
      do_req(4'h0, 32'h0000_0010, 32'h0, 0);
      check("full_write_model", model_mem[4], 32'hDEADBEEF);
      do_req(4'b0010, 32'h0000_0010, 32'h0000_5A00, 0);
      check("partial_model", model_mem[4], 32'hDEAD5AEF);
      do_req(4'h0, 32'h0000_0010, 32'h0, 6);
      do_req(4'hF, 32'h0000_1010, 32'h11223344, 0);
      do_req(4'h0, 32'h0000_0012, 32'h0, 2);

      // Reset two cycles after acceptance must abandon the write.
      do_req(4'hF, 32'h0000_0020, 32'h0, 0);
      req_valid = 1'b1; req_be = 4'hF; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("abort_rsp_rdata", rsp_rdata, 32'd0);
      check("abort_is_write", {31'b0, rsp_is_write}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_req(4'h0, 32'h0000_0020, 32'h0, 0);

      for (int k = 0; k < 8; k++)
         do_req(4'($urandom_range(0, 15)), {20'h0, 8'($urandom_range(0, 7)), 4'h0},
                $urandom, $urandom_range(0, 3));

      // LATENCY=1 back-to-back full-word writes with rsp_ready held high.
      req_valid_1 = 1'b1; rsp_ready_1 = 1'b1; req_be_1 = 4'hF; prev = -1;
      for (int i = 0; i < 4; i++) begin
         req_addr_1 = 32'(i * 4); req_wdata_1 = 32'hA500_0000 + 32'(i);
         n = 0;
         while (!req_ready_1 && n < 10) begin @(posedge clk); #1; n++; end
         check("lat1_ready", {31'b0, req_ready_1}, 32'd1);
         acc = cyc;
         @(posedge clk); #1;
         check("lat1_wait", {31'b0, rsp_valid_1}, 32'd0);
         @(posedge clk); #1;
         check("lat1_valid", {31'b0, rsp_valid_1}, 32'd1);
         check("lat1_rdata", rsp_rdata_1, 32'hA500_0000 + 32'(i));
         check("lat1_is_write", {31'b0, rsp_is_write_1}, 32'd1);
         if (prev >= 0) check("lat1_spacing", acc - prev, 32'd3);
         prev = acc;
         @(posedge clk); #1;
      end
      req_valid_1 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
